pipelined_sklansky_adder: RTL

PIPELINED_SKLANSKY_ADDER -- requirements
Module: pipelined_sklansky_adder

---
 rtl/pipelined_sklansky_adder_pkg.sv | 41 ++++
 rtl/pipelined_sklansky_adder_prefix_level.sv | 26 ++
 rtl/pipelined_sklansky_adder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipelined_sklansky_adder_pkg.sv
// Shared helpers for the pipelined Sklansky adder: prefix depth, register placement, g/p pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipelined_sklansky_adder_pkg;

    // Generate/propagate pair carried through the prefix tree.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of Sklansky prefix levels, ceil(log2(width)).
    function automatic int prefix_levels(input int width);
        int l;
        l = 0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) < width) begin
                l = i + 1;
            end
        end
        return l;
    endfunction

    // Steps are numbered 0 = pre-processing, 1..L = prefix levels, L+1 = post-processing.
    // Returns 1 when a register boundary sits after the given step. The final step is
    // always registered; the remaining stages-1 boundaries are spread evenly over the
    // L+1 interior cut points.
    function automatic bit stage_reg_after(input int step, input int width, input int stages);
        int n;
        bit r;
        n = prefix_levels(width) + 2;
        r = (step == n - 1);
        for (int j = 1; j < stages; j++) begin
            if (((j * n) / stages) - 1 == step) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_sklansky_adder_prefix_level.sv
// One Sklansky prefix level: upper half of each 2^(LEVEL+1) block merges with the lower half's last element.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: gp_in - g/p pairs entering the level; gp_out - g/p pairs after this level's merges.
module sklansky_prefix_level
    import pipelined_sklansky_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 0
) (
    input  gp_t [WIDTH-1:0] gp_in,
    output gp_t [WIDTH-1:0] gp_out
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i >> LEVEL) & 1) == 1) begin : g_merge
            // Last element of the lower half of this block.
            localparam int J = ((i >> LEVEL) << LEVEL) - 1;
            assign gp_out[i].g = gp_in[i].g | (gp_in[i].p & gp_in[J].g);
            assign gp_out[i].p = gp_in[i].p & gp_in[J].p;
        end else begin : g_pass
            assign gp_out[i] = gp_in[i];
        end
    end

endmodule

// File: rtl/pipelined_sklansky_adder.sv
// Pipelined Sklansky parallel-prefix adder: sum/cout/ovf of a+b+cin.
// Latency: PIPE_STAGES cycles from transfer to out_valid, one result per cycle.
// Backpressure: single global advance (adv = !out_valid || out_ready); all stages freeze when blocked.
// Ports: clk/rst (async active-high); in_valid/in_ready/a/b/cin operand handshake;
//        out_valid/out_ready/sum/cout/ovf result handshake, outputs registered.
module pipelined_sklansky_adder
    import pipelined_sklansky_adder_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = prefix_levels(WIDTH);

    // Values leaving step k (after its register, if it has one).
    gp_t  [WIDTH-1:0] st_gp [0:LEVELS];
    logic [WIDTH-1:0] st_hp [0:LEVELS];
    logic             st_c  [0:LEVELS];
    logic             st_v  [0:LEVELS];

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k <= LEVELS; k++) begin : g_step
        gp_t  [WIDTH-1:0] nx_gp;
        logic [WIDTH-1:0] nx_hp;
        logic             nx_c;
        logic             nx_v;

        if (k == 0) begin : g_pre
            always_comb begin
                for (int i = 0; i < WIDTH; i++) begin
                    nx_gp[i].g = a[i] & b[i];
                    nx_gp[i].p = a[i] ^ b[i];
                end
                // cin acts as the generate of bit -1; merging it here makes every
                // group ending at bit 0 a true carry, so nothing ever propagates past it.
                nx_gp[0].g = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
                nx_gp[0].p = 1'b0;
            end
            assign nx_hp = a ^ b;
            assign nx_c  = cin;
            assign nx_v  = in_valid;
        end else begin : g_lvl
            sklansky_prefix_level #(
                .WIDTH (WIDTH),
                .LEVEL (k - 1)
            ) u_level (
                .gp_in  (st_gp[k-1]),
                .gp_out (nx_gp)
            );
            assign nx_hp = st_hp[k-1];
            assign nx_c  = st_c[k-1];
            assign nx_v  = st_v[k-1];
        end

        if (stage_reg_after(k, WIDTH, PIPE_STAGES)) begin : g_reg
            gp_t  [WIDTH-1:0] r_gp;
            logic [WIDTH-1:0] r_hp;
            logic             r_c;
            logic             r_v;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_gp <= '0;
                    r_hp <= '0;
                    r_c  <= 1'b0;
                    r_v  <= 1'b0;
                end else if (adv) begin
                    r_gp <= nx_gp;
                    r_hp <= nx_hp;
                    r_c  <= nx_c;
                    r_v  <= nx_v;
                end
            end

            assign st_gp[k] = r_gp;
            assign st_hp[k] = r_hp;
            assign st_c[k]  = r_c;
            assign st_v[k]  = r_v;
        end else begin : g_wire
            assign st_gp[k] = nx_gp;
            assign st_hp[k] = nx_hp;
            assign st_c[k]  = nx_c;
            assign st_v[k]  = nx_v;
        end
    end

    // Post-processing: carry into bit i is the prefix generate of bits -1..i-1.
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] fin_p_unused;
    logic [WIDTH-1:0] sum_nx;
    logic             cout_nx;
    logic             ovf_nx;

    always_comb begin
        carry[0] = st_c[LEVELS];
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = st_gp[LEVELS][i-1].g;
        end
        for (int i = 0; i < WIDTH; i++) begin
            fin_p_unused[i] = st_gp[LEVELS][i].p;
        end
    end

    assign sum_nx  = st_hp[LEVELS] ^ carry;
    assign cout_nx = st_gp[LEVELS][WIDTH-1].g;
    assign ovf_nx  = cout_nx ^ carry[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= st_v[LEVELS];
            sum       <= sum_nx;
            cout      <= cout_nx;
            ovf       <= ovf_nx;
        end
    end

endmodule
